mips_prefetch_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_prefetch_unit_if.sv | 29 ++
 rtl/mips_fetch_fifo.sv | 48 ++++
 rtl/mips_prefetch_unit.sv | 131 +++++++++++++
 tb/tb_mips_prefetch_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: opcodes and the
// prefetch state encoding.
package mips_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } fetch_state_e;

  function automatic logic is_hlt(input logic [5:0] op);
    return op == OP_HLT;
  endfunction

endpackage

// File: rtl/mips_prefetch_unit_if.sv
// Instruction-memory fetch channel: valid/ready requests,
// in-order responses without back-pressure.
interface mips_prefetch_unit_if #(
  parameter int AW = 10
) ();

  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/mips_fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; used for
// fetched {ir, npc} pairs and for in-flight fetch addresses.
module mips_fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !i_flush && (r_cnt != CW'(DEPTH));
  assign w_pop  = i_pop && (r_cnt != '0);

  always_ff @(posedge clk1) begin
    if (rst || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk1) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/mips_prefetch_unit.sv
// Instruction prefetch ahead of IF/ID: credit-limited word fetches,
// redirect flush with stale-response dropping, and HLT stop.
module mips_prefetch_unit
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                clk1,
  input  logic                rst,
  mips_prefetch_unit_if.master imem,
  input  logic                redirect_valid,
  input  logic [AW-1:0]       redirect_pc,
  output logic                id_valid,
  output logic [31:0]         id_ir,
  output logic [31:0]         id_npc,
  input  logic                id_ready,
  output logic                halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_outst;
  logic [CW-1:0] w_after;
  logic [CW:0]   w_used;
  logic [63:0]   w_head;
  logic [63:0]   w_entry;
  logic [AW-1:0] w_rsp_addr;
  logic          w_fetch;
  logic          w_req;
  logic          w_fire;
  logic          w_deq;
  logic          w_hlt;
  logic          w_redir;
  logic          w_enq;
  logic          w_flush;

  assign w_fetch = (r_state == S_FETCH);
  assign w_used  = {1'b0, w_occ} + {1'b0, w_outst};
  assign w_req   = w_fetch && !rst && !redirect_valid
                && (w_used < (CW+1)'(DEPTH));
  assign w_fire  = w_req && imem.imem_req_ready;

  assign imem.imem_req_valid = w_req;
  assign imem.imem_req_addr  = r_pc;

  assign id_valid = w_fetch && !rst && (w_occ != '0);
  assign id_ir    = id_valid ? w_head[63:32] : '0;
  assign id_npc   = id_valid ? w_head[31:0]  : '0;
  assign halted   = (r_state == S_HALT);

  assign w_deq   = id_valid && id_ready;
  assign w_hlt   = w_deq && is_hlt(w_head[63:58]);
  assign w_redir = w_fetch && redirect_valid && !w_hlt;
  assign w_flush = w_redir || w_hlt || !w_fetch;

  // A response arriving alongside a redirect is stale as well
  assign w_enq = imem.imem_rsp_valid && w_fetch
              && !redirect_valid && (r_drop == '0);
  assign w_after = w_outst - CW'(imem.imem_rsp_valid);

  assign w_entry = {imem.imem_rsp_data,
                    {{(32-AW){1'b0}}, w_rsp_addr} + 32'd1};

  mips_fetch_fifo #(
    .W     (AW),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk1    (clk1),
    .rst     (rst),
    .i_flush (1'b0),
    .i_push  (w_fire),
    .i_wdata (r_pc),
    .i_pop   (imem.imem_rsp_valid),
    .o_rdata (w_rsp_addr),
    .o_count (w_outst)
  );

  mips_fetch_fifo #(
    .W     (64),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk1    (clk1),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_enq),
    .i_wdata (w_entry),
    .i_pop   (w_deq),
    .o_rdata (w_head),
    .o_count (w_occ)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_pc <= '0;
    end else if (w_redir) begin
      r_pc <= redirect_pc;
    end else if (w_fire) begin
      r_pc <= r_pc + AW'(1);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_redir) begin
      r_drop <= w_after;
    end else if (imem.imem_rsp_valid && (r_drop != '0)) begin
      r_drop <= r_drop - CW'(1);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH: if (w_hlt) w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_mips_prefetch_unit.sv
// Bench for mips_prefetch_unit: behavioural memory with set latency,
// expected {ir, npc} queue filled at request acceptance.
module tb_mips_prefetch_unit;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } pend_t;

  logic          clk1 = 1'b0;
  logic          rst  = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          id_valid;
  logic [31:0]   id_ir;
  logic [31:0]   id_npc;
  logic          id_ready = 1'b0;
  logic          halted;

  mips_prefetch_unit_if #(.AW(AW)) imem ();

  mips_prefetch_unit #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk1           (clk1),
    .rst            (rst),
    .imem           (imem.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ir          (id_ir),
    .id_npc         (id_npc),
    .id_ready       (id_ready),
    .halted         (halted)
  );

  always #5 clk1 = ~clk1;

  logic [31:0]   mem [1024];
  pend_t         pend [$];
  logic [63:0]   exp_q [$];
  logic [AW-1:0] mpc;
  logic [31:0]   last_ir, last_npc;
  bit            mhalt, saw400;
  int            cyc, lat, n_acc, n_del, first_idv;
  int            total, bad;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, want, cyc);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit rv,
                      input logic [AW-1:0] rpc);
    logic [63:0] e;
    @(negedge clk1);
    rst = r;
    id_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data = '0;
    if (r) begin
      pend.delete();
      exp_q.delete();
      mpc = '0;
      mhalt = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data = mem[pend[0].a];
      void'(pend.pop_front());
    end
    #1;
    if (!r) begin
      if (mhalt) begin
        chk("halt_req", 64'(imem.imem_req_valid), 0);
        chk("halt_idv", 64'(id_valid), 0);
        chk("halted", 64'(halted), 1);
      end
      if (imem.imem_req_valid) begin
        chk("req_addr", 64'(imem.imem_req_addr), 64'(mpc));
        if (imem.imem_req_ready) begin
          pend.push_back('{imem.imem_req_addr, cyc + lat});
          exp_q.push_back({mem[mpc], 32'(mpc) + 32'd1});
          mpc = mpc + AW'(1);
          n_acc++;
        end
      end
      if (id_valid && id_ready) begin
        n_del++;
        last_ir = id_ir;
        last_npc = id_npc;
        if (id_npc == 32'h400) saw400 = 1'b1;
        if (first_idv < 0) first_idv = cyc;
        chk("del_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("id_ir", 64'(id_ir), 64'(e[63:32]));
          chk("id_npc", 64'(id_npc), 64'(e[31:0]));
          if (e[63:58] == OP_HLT) begin
            mhalt = 1'b1;
            exp_q.delete();
          end
        end
      end
      if (rv && !mhalt) begin
        exp_q.delete();
        mpc = rpc;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int l);
    lat = l;
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);
    n_acc = 0;
    n_del = 0;
    first_idv = -1;
  endtask

  task automatic wait_del(input string tag, input int prev);
    for (int k = 0; k < 40 && n_del == prev; k++) step(0, 1, 0, '0);
    chk(tag, 64'(n_del > prev), 1);
  endtask

  initial begin
    int c0, d0;
    total = 0;
    bad = 0;
    cyc = 0;
    saw400 = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data = '0;

    // reset values
    do_reset(1);
    chk("rst_req", 64'(imem.imem_req_valid), 0);
    chk("rst_idv", 64'(id_valid), 0);
    chk("rst_ir", 64'(id_ir), 0);
    chk("rst_npc", 64'(id_npc), 0);
    chk("rst_halt", 64'(halted), 0);

    // streaming with 1-cycle memory
    c0 = cyc;
    step(0, 1, 0, '0);
    chk("first_req", 64'(imem.imem_req_valid), 1);
    chk("first_addr", 64'(imem.imem_req_addr), 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, '0);
    chk("first_idv_cyc", 64'(first_idv), 64'(c0 + 2));
    d0 = n_del;
    for (int k = 0; k < 10; k++) step(0, 1, 0, '0);
    chk("rate", 64'(n_del - d0), 10);

    // decode stall: credit limit
    do_reset(1);
    for (int k = 0; k < 10; k++) step(0, 0, 0, '0);
    chk("stall_acc", 64'(n_acc), 4);
    chk("stall_req", 64'(imem.imem_req_valid), 0);
    for (int k = 0; k < 20; k++) step(0, 1, 0, '0);
    chk("stall_resume", 64'(n_del >= 15), 1);

    // 3-cycle memory, redirect with fetches in flight
    do_reset(3);
    for (int k = 0; k < 20 && pend.size() < 3; k++) step(0, 1, 0, '0);
    chk("inflight3", 64'(pend.size()), 3);
    step(0, 1, 1, AW'(32'h20));
    d0 = n_del;
    wait_del("redir3_tmo", d0);
    chk("redir3_ir", 64'(last_ir), 64'h20);
    chk("redir3_npc", 64'(last_npc), 64'h21);
    for (int k = 0; k < 10; k++) step(0, 1, 0, '0);

    // redirect with simultaneous response and id handshake
    do_reset(1);
    for (int k = 0; k < 8; k++) step(0, 1, 0, '0);
    d0 = n_del;
    step(0, 1, 1, AW'(32'h40));
    chk("redir_hs", 64'(n_del - d0), 1);
    d0 = n_del;
    wait_del("redir1_tmo", d0);
    chk("redir1_ir", 64'(last_ir), 64'h40);
    for (int k = 0; k < 5; k++) step(0, 1, 0, '0);

    // HLT at address 5
    mem[5] = {OP_HLT, 26'd0};
    do_reset(1);
    for (int k = 0; k < 30 && !mhalt; k++) step(0, 1, 0, '0);
    chk("hlt_seen", 64'(mhalt), 1);
    chk("hlt_ir", 64'(last_ir), {32'd0, OP_HLT, 26'd0});
    for (int k = 0; k < 5; k++) step(0, 1, 0, '0);
    step(0, 1, 1, AW'(32'h10));
    for (int k = 0; k < 5; k++) step(0, 1, 0, '0);
    chk("hlt_hold", 64'(halted), 1);
    mem[5] = 32'd5;
    do_reset(1);
    chk("hlt_rst", 64'(halted), 0);
    step(0, 1, 0, '0);
    chk("restart_req", 64'(imem.imem_req_valid), 1);
    chk("restart_addr", 64'(imem.imem_req_addr), 0);
    for (int k = 0; k < 10; k++) step(0, 1, 0, '0);

    // pc wrap at the top of memory
    do_reset(1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, '0);
    saw400 = 1'b0;
    step(0, 1, 1, AW'(32'h3FE));
    for (int k = 0; k < 10; k++) step(0, 1, 0, '0);
    chk("wrap_npc", 64'(saw400), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
